// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage: either a two-entry skid buffer with a registered
// in_ready, or a single register with pass-through ready. Includes a stall counter.
module pipe_skid_stage #(
  parameter int unsigned     DW         = 128,
  parameter int unsigned     SKID       = 1,
  parameter logic [DW-1:0]   BUBBLE_VAL = {DW{1'b0}},
  parameter int unsigned     CW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy,
  input  logic          clr_stats,
  output logic [CW-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          rdy_q, rdy_d;
  logic [CW-1:0] stall_q, stall_d;
  logic          accept_s;
  logic          fire_s;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;
  assign accept_s  = in_valid & in_ready;
  assign fire_s    = out_valid & out_ready;

  // Skid mode breaks the out_ready -> in_ready path with a flop; otherwise ready passes through.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = rdy_q;
    end else begin : g_pass
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

  // Occupancy FSM and payload steering; vacated entries fall back to BUBBLE_VAL.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && fire_s) begin
          main_d = in_data;
        end else if (accept_s) begin
          skid_d  = in_data;
          state_d = ST_TWO;
        end else if (fire_s) begin
          main_d  = BUBBLE_VAL;
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        if (fire_s) begin
          main_d  = skid_q;
          skid_d  = BUBBLE_VAL;
          state_d = ST_ONE;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: begin
        main_d  = BUBBLE_VAL;
        skid_d  = BUBBLE_VAL;
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
      state_d = ST_EMPTY;
    end
    rdy_d = (state_d != ST_TWO);
  end

  // Saturating backpressure counter; clr_stats wins over the increment.
  always_comb begin
    stall_d = stall_q;
    if (clr_stats) begin
      stall_d = {CW{1'b0}};
    end else if (out_valid && !out_ready && (stall_q != {CW{1'b1}})) begin
      stall_d = stall_q + CW'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      rdy_q   <= 1'b1;
      stall_q <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a skid instance (DW=32, CW=4) and a
// pass-through instance (DW=32, CW=16) checked every cycle against queue models.
module tb_pipe_skid_stage;

  localparam logic [31:0] BUB1 = 32'hDEAD_BEEF;
  localparam logic [31:0] BUB0 = 32'h0BAD_F00D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1, clr1;
  logic [31:0] in_data1, out_data1;
  logic [1:0]  occ1;
  logic [3:0]  stall1;

  logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0, clr0;
  logic [31:0] in_data0, out_data0;
  logic [1:0]  occ0;
  logic [15:0] stall0;

  pipe_skid_stage #(.DW(32), .SKID(1), .BUBBLE_VAL(BUB1), .CW(4)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .occupancy(occ1), .clr_stats(clr1), .stall_cnt(stall1)
  );

  pipe_skid_stage #(.DW(32), .SKID(0), .BUBBLE_VAL(BUB0), .CW(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .occupancy(occ0), .clr_stats(clr0), .stall_cnt(stall0)
  );

  logic [31:0] q1[$];
  logic [31:0] q0[$];
  int st1, st0;
  int total_cnt = 0;
  int bad_cnt = 0;
  int rx0 = 0;
  int n0 = 0;
  logic acc0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: compare outputs with the models, then advance the models at the edge.
  task automatic tick();
    logic v1, v0, r0, a1, f1, f0;
    #1;
    v1 = (q1.size() != 0);
    v0 = (q0.size() != 0);
    r0 = out_ready0 | ~v0;
    chk("valid1", out_valid1, v1);
    chk("data1", out_data1, v1 ? q1[0] : BUB1);
    chk("occ1", occ1, q1.size());
    chk("rdy1", in_ready1, q1.size() < 2);
    chk("stall1", stall1, st1);
    chk("valid0", out_valid0, v0);
    chk("data0", out_data0, v0 ? q0[0] : BUB0);
    chk("occ0", occ0, q0.size());
    chk("rdy0", in_ready0, r0);
    chk("stall0", stall0, st0);
    a1   = in_valid1 & (q1.size() < 2);
    f1   = v1 & out_ready1;
    acc0 = in_valid0 & r0;
    f0   = v0 & out_ready0;
    @(posedge clk);
    if (rst) begin
      q1.delete(); q0.delete(); st1 = 0; st0 = 0;
    end else begin
      if (flush1) q1.delete();
      else begin
        if (f1) void'(q1.pop_front());
        if (a1) q1.push_back(in_data1);
      end
      if (clr1) st1 = 0;
      else if (v1 && !out_ready1 && st1 < 15) st1++;
      if (flush0) q0.delete();
      else begin
        if (f0) begin void'(q0.pop_front()); rx0++; end
        if (acc0) q0.push_back(in_data0);
      end
      if (clr0) st0 = 0;
      else if (v0 && !out_ready0 && st0 < 65535) st0++;
    end
    #1;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = 32'h0; out_ready1 = 1'b1; clr1 = 1'b0;
    flush0 = 1'b0; in_valid0 = 1'b0; in_data0 = 32'h0; out_ready0 = 1'b1; clr0 = 1'b0;
    st1 = 0; st0 = 0; acc0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Single payload latency
    in_valid1 = 1'b1; in_data1 = 32'h11; tick();
    in_valid1 = 1'b0; tick(); tick();

    // Fill to two entries under backpressure, then drain
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 32'hA; tick();
    in_data1 = 32'hB; tick();
    in_valid1 = 1'b0; tick();
    chk("full_occ", occ1, 32'd2);
    out_ready1 = 1'b1; tick(); tick(); tick();

    // Flush a full stage while offering 0xC
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 32'h1; tick();
    in_data1 = 32'h2; tick();
    flush1 = 1'b1; in_data1 = 32'hC; out_ready1 = 1'b1; tick();
    flush1 = 1'b0; in_valid1 = 1'b0; tick(); tick();

    // Sustained back-to-back throughput
    in_valid1 = 1'b1;
    for (int i = 0; i < 8; i++) begin in_data1 = 32'h100 + i; tick(); end
    in_valid1 = 1'b0; tick(); tick();

    // Stall counter saturation and clear
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 32'h55; tick(); in_valid1 = 1'b0;
    out_ready1 = 1'b0;
    repeat (20) tick();
    chk("stall_sat", stall1, 32'd15);
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    chk("stall_clr", stall1, 32'd0);
    out_ready1 = 1'b1; tick(); tick();

    // Random traffic on the skid stage; ordered 0..99 stream on the pass-through stage
    cyc = 0;
    in_valid0 = 1'b1; in_data0 = 32'd0;
    while ((rx0 < 100 || cyc < 200) && cyc < 3000) begin
      in_valid1  = 1'($urandom_range(0, 1));
      in_data1   = $urandom;
      out_ready1 = 1'($urandom_range(0, 1));
      out_ready0 = 1'($urandom_range(0, 1));
      tick();
      if (acc0) n0++;
      in_data0  = n0;
      in_valid0 = (n0 < 100);
      cyc++;
    end
    chk("rx0_count", rx0, 32'd100);
    in_valid1 = 1'b0; in_valid0 = 1'b0;
    out_ready1 = 1'b1; out_ready0 = 1'b1;
    tick(); tick();

    // Reset with the skid stage full
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 32'h77; tick();
    in_data1 = 32'h78; tick();
    in_valid1 = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_occ", occ1, 32'd0);
    chk("rst_data", out_data1, BUB1);
    out_ready1 = 1'b1; tick(); tick();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
